link_rx_buffer: RTL and testbench
=================================

// Module: link_rx_buffer
// PURPOSE
//  Responder end of the 4-phase req/ack link: accepts words from the link master, acks each one,
//  and queues it in a small FIFO for a downstream consumer (valid/ready). Link-level backpressure:
//  no ack is issued while the FIFO is full. Sits in link_top beside the master as an alternative
//  slave. Counts completed transfers.
// PARAMETERS
//  DATA_W  8  link/FIFO data width
//  DEPTH   4  FIFO entries; power of 2, >= 2
//  CNT_W   8  width of xfer_cnt (wraps modulo 2**CNT_W)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst_n      in   1                   asynchronous, active-low reset
//  req        in   1                   link request from master (same clock domain, no sync)
//  data_in    in   DATA_W              link data, stable while req=1
//  ack        out  1                   link acknowledge, registered
//  out_valid  out  1                   FIFO head valid (= !empty)
//  out_data   out  DATA_W              FIFO head word (show-ahead)
//  out_ready  in   1                   consumer pop; pop occurs when out_valid & out_ready
//  level      out  $clog2(DEPTH+1)     current FIFO occupancy
//  full       out  1                   level == DEPTH
//  xfer_cnt   out  CNT_W               completed transfers (ack rising edges)
// BEHAVIOUR
//  - Reset (rst_n=0, any time, incl. mid-handshake): state=S_IDLE, ack=0, rd/wr ptrs=0, level=0,
//    out_valid=0, full=0, xfer_cnt=0. FIFO memory contents are don't-care; out_data is don't-care
//    while out_valid=0.
//  - FSM, 2 states:
//    S_IDLE: ack=0. On an edge with req=1 & !full: write data_in to FIFO, ack<=1, xfer_cnt+=1,
//      ->S_ACK. If req=1 & full: stay, ack stays 0 (master waits).
//    S_ACK: ack=1. On an edge with req=0: ack<=0, ->S_IDLE. Otherwise hold. data_in is ignored.
//  - Latency: req sampled high at edge N (FIFO not full) -> ack=1 and out_valid=1 after edge N.
//    req sampled low at edge M -> ack=0 after edge M. Minimum one S_IDLE cycle between transfers.
//  - Exactly one push per handshake, regardless of how long req stays high.
//  - FIFO: push from FSM, pop from consumer. Push and pop on the same edge: both occur, level
//    unchanged. Push is never attempted when full. Pop with out_valid=0 is ignored.
//    Pointers wrap modulo DEPTH. level updates +1/-1/0 accordingly.
//  - full is evaluated at the S_IDLE decision edge using the registered level. A pop on that same
//    edge does not unblock the push. The push happens on the next edge.
//  - xfer_cnt wraps from 2**CNT_W-1 to 0 silently.
// STRUCTURE
//  - Package link_pkg: state encoding (S_IDLE, S_ACK) and the default link DATA_W, shared with the
//    master.
//  - Sub-module link_rx_fifo #(DATA_W, DEPTH): synchronous show-ahead FIFO with push/pop/level/full/
//    empty, async active-low reset. The top holds the FSM, ack register and xfer_cnt.
// TESTING
//  1 Reset mid-handshake: in S_ACK with level=2, pull rst_n=0 -> ack=0, out_valid=0, level=0,
//    xfer_cnt=0 immediately (async). After release, S_IDLE.
//  2 Single transfer, out_ready=0: req=1, data_in=0xA5 -> after next edge ack=1, out_valid=1,
//    out_data=0xA5, level=1, xfer_cnt=1. Then req=0 -> after next edge ack=0.
//  3 Four transfers 0x11,0x22,0x33,0x44 with out_ready=1 -> consumer receives 0x11..0x44 in order,
//    xfer_cnt=4, level=0 at end.
//  4 Backpressure, DEPTH=4, out_ready=0: five requests -> four acked, level=4, full=1. The fifth
//    req stays high with ack=0. Pulse out_ready for one cycle -> the fifth is acked on the
//    following edge, level=4.
//  5 Simultaneous push+pop: level=1, head=0x10, out_ready=1 on the same edge as accepting 0x20 ->
//    level stays 1, out_data=0x20.
//  6 Wrap: CNT_W=2, DEPTH=4, four transfers with out_ready=1 -> xfer_cnt sequence 1,2,3,0.
//    FIFO pointers wrap with order intact.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: link state encoding and default data width shared by link master and responders
package link_pkg;
  localparam int LINK_DATA_W = 8;
  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} link_state_e;
endpackage

// File: rtl/link_rx_buffer_if.sv
// link_rx_buffer_if: req/ack link plus valid/ready consumer side of the rx buffer
interface link_rx_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);
  logic              req;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic [CNT_W-1:0]  xfer_cnt;
  modport master (output req, data_in, out_ready, input ack, out_valid, out_data, level, full, xfer_cnt);
  modport slave  (input req, data_in, out_ready, output ack, out_valid, out_data, level, full, xfer_cnt);
endinterface

// File: rtl/link_rx_fifo.sv
// link_rx_fifo: show-ahead FIFO; push when full and pop when empty are ignored
module link_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            din_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign empty_o = level_q == '0;
  assign full_o  = level_q == LW'(DEPTH);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_q];
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end
  // storage is not reset; contents are meaningless until written
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
endmodule

// File: rtl/link_rx_buffer.sv
// link_rx_buffer: 4-phase link responder that queues each accepted word for a valid/ready consumer
module link_rx_buffer
  import link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  link_rx_buffer_if.slave  bus
);
  link_state_e state_q, state_d;
  logic ack_q, ack_d, push, full, empty;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  link_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .din_i(bus.data_in), .pop_i(bus.out_ready),
    .dout_o(bus.out_data), .level_o(bus.level), .full_o(full), .empty_o(empty)
  );
  assign bus.ack       = ack_q;
  assign bus.full      = full;
  assign bus.out_valid = ~empty;
  assign bus.xfer_cnt  = cnt_q;
  // handshake: accept once per req when space exists (registered full), release on req low
  always_comb begin
    push    = 1'b0;
    state_d = state_q;
    ack_d   = ack_q;
    if (state_q == S_IDLE) begin
      push    = bus.req & ~full;
      state_d = push ? S_ACK : S_IDLE;
      ack_d   = push;
    end else begin
      state_d = bus.req ? S_ACK : S_IDLE;
      ack_d   = bus.req;
    end
    cnt_d = cnt_q + CNT_W'(push);
  end
  // state, ack and transfer counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_link_rx_buffer.sv
// tb_link_rx_buffer: directed link transfers with a queue scoreboard checking consumer data
module tb_link_rx_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cnt_m = 0;
  logic [7:0] sb [$];
  always #5 clk = ~clk;
  link_rx_buffer_if #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) b1 ();
  link_rx_buffer_if #(.DATA_W(8), .DEPTH(4), .CNT_W(2)) b2 ();
  assign b2.req = b1.req;
  assign b2.data_in = b1.data_in;
  assign b2.out_ready = b1.out_ready;
  link_rx_buffer #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  link_rx_buffer #(.DATA_W(8), .DEPTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    b1.req = 1'b0;
    b1.out_ready = 1'b0;
    sb.delete();
    cnt_m = 0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic xfer(input logic [7:0] d);
    int n;
    b1.req = 1'b1;
    b1.data_in = d;
    sb.push_back(d);
    n = 0;
    do begin step(); n++; end while (!b1.ack && n < 20);
    chk("ack_rise", {31'd0, b1.ack}, 32'd1);
    cnt_m++;
    chk("xfer_cnt", {24'd0, b1.xfer_cnt}, cnt_m);
    chk("xfer_cnt_w2", {30'd0, b2.xfer_cnt}, cnt_m % 4);
    b1.req = 1'b0;
    step();
    chk("ack_fall", {31'd0, b1.ack}, 32'd0);
    step();
  endtask

  // consumer monitor: every pop must deliver the oldest outstanding word
  always @(negedge clk)
    if (rst_n && b1.out_valid && b1.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h expected none", b1.out_data);
      end else begin
        if (b1.out_data !== sb[0]) begin
          failures++;
          $display("FAIL pop_data: got %0h expected %0h", b1.out_data, sb[0]);
        end
        void'(sb.pop_front());
      end
    end

  initial begin
    b1.req = 1'b0;
    b1.data_in = '0;
    b1.out_ready = 1'b0;
    do_reset();
    // reset in the middle of a handshake with two words buffered
    xfer(8'h01);
    b1.req = 1'b1;
    b1.data_in = 8'h02;
    step();
    chk("t1_ack_pre", {31'd0, b1.ack}, 32'd1);
    chk("t1_level_pre", {29'd0, b1.level}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_ack", {31'd0, b1.ack}, 32'd0);
    chk("t1_valid", {31'd0, b1.out_valid}, 32'd0);
    chk("t1_level", {29'd0, b1.level}, 32'd0);
    chk("t1_cnt", {24'd0, b1.xfer_cnt}, 32'd0);
    sb.delete();
    cnt_m = 0;
    b1.req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t1_idle_ack", {31'd0, b1.ack}, 32'd0);
    // single transfer, consumer stalled
    b1.req = 1'b1;
    b1.data_in = 8'hA5;
    sb.push_back(8'hA5);
    step();
    chk("t2_ack", {31'd0, b1.ack}, 32'd1);
    chk("t2_valid", {31'd0, b1.out_valid}, 32'd1);
    chk("t2_data", {24'd0, b1.out_data}, 32'hA5);
    chk("t2_level", {29'd0, b1.level}, 32'd1);
    chk("t2_cnt", {24'd0, b1.xfer_cnt}, 32'd1);
    b1.req = 1'b0;
    step();
    chk("t2_ack_fall", {31'd0, b1.ack}, 32'd0);
    // four transfers with consumer always ready; dut2 shows 1,2,3,0 counter wrap
    do_reset();
    b1.out_ready = 1'b1;
    xfer(8'h11); xfer(8'h22); xfer(8'h33); xfer(8'h44);
    step(); step();
    chk("t3_cnt", {24'd0, b1.xfer_cnt}, 32'd4);
    chk("t3_level", {29'd0, b1.level}, 32'd0);
    chk("t3_sb_empty", sb.size(), 32'd0);
    // backpressure: fifth request waits until one word is popped
    do_reset();
    xfer(8'hB1); xfer(8'hB2); xfer(8'hB3); xfer(8'hB4);
    chk("t4_level", {29'd0, b1.level}, 32'd4);
    chk("t4_full", {31'd0, b1.full}, 32'd1);
    b1.req = 1'b1;
    b1.data_in = 8'hB5;
    sb.push_back(8'hB5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_ack_held", {31'd0, b1.ack}, 32'd0);
    end
    b1.out_ready = 1'b1;
    step();
    b1.out_ready = 1'b0;
    chk("t4_ack_popedge", {31'd0, b1.ack}, 32'd0);
    chk("t4_level_pop", {29'd0, b1.level}, 32'd3);
    chk("t4_full_pop", {31'd0, b1.full}, 32'd0);
    step();
    chk("t4_ack_late", {31'd0, b1.ack}, 32'd1);
    chk("t4_level_refill", {29'd0, b1.level}, 32'd4);
    chk("t4_cnt", {24'd0, b1.xfer_cnt}, 32'd5);
    b1.req = 1'b0;
    step();
    chk("t4_ack_fall", {31'd0, b1.ack}, 32'd0);
    b1.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t4_drained", {29'd0, b1.level}, 32'd0);
    // push and pop on the same edge
    do_reset();
    xfer(8'h10);
    b1.req = 1'b1;
    b1.data_in = 8'h20;
    sb.push_back(8'h20);
    b1.out_ready = 1'b1;
    step();
    b1.out_ready = 1'b0;
    chk("t5_ack", {31'd0, b1.ack}, 32'd1);
    chk("t5_level", {29'd0, b1.level}, 32'd1);
    chk("t5_data", {24'd0, b1.out_data}, 32'h20);
    b1.req = 1'b0;
    step();
    b1.out_ready = 1'b1;
    step(); step();
    chk("t5_drained", {29'd0, b1.level}, 32'd0);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
